// File: rtl/read_cmd_decoder.sv
// read_cmd_decoder: serial board command decoder emitting read/command/parity-error strobes.
// Define READ_CMD_ERRCNT_EN to add the saturating ErrCnt parity-error counter output.
module read_cmd_decoder #(
    parameter logic [3:0]  WildAddr = 4'b1111,
    parameter logic [10:0] ReadCode = 11'b11111110010
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CmdIn,
    input  logic [3:0]  BoardAddr,
    output logic        RxBusy,
    output logic        ReadStrobe,
    output logic [1:0]  ReadTag,
    output logic        CmdStrobe,
    output logic [13:0] CmdWord,
    output logic        PrtyErr
`ifdef READ_CMD_ERRCNT_EN
    ,
    output logic [7:0]  ErrCnt
`endif
);
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SHFT = 3'b010,
        EVAL = 3'b100
    } state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [17:0] sr_q, sr_d;
    logic        read_strobe_q, read_strobe_d;
    logic        cmd_strobe_q, cmd_strobe_d;
    logic        prty_err_q, prty_err_d;
    logic [1:0]  read_tag_q, read_tag_d;
    logic [13:0] cmd_word_q, cmd_word_d;
    logic        addr_hit, is_read, prty_ok;
    // Frame fields after 18 shifts: {Addr[3:0], Word[10:0], Prty, Tag[1:0]}
    assign addr_hit = (sr_q[17:14] == BoardAddr) || (sr_q[17:14] == WildAddr);
    assign is_read  = sr_q[13:3] == ReadCode;
    assign prty_ok  = sr_q[2] == (sr_q[1] ^ sr_q[0]);
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        read_strobe_d = 1'b0;
        cmd_strobe_d  = 1'b0;
        prty_err_d    = 1'b0;
        read_tag_d    = read_tag_q;
        cmd_word_d    = cmd_word_q;
        unique case (state_q)
            IDLE: begin
                if (CmdIn) begin
                    state_d = SHFT;
                    cnt_d   = 5'd0;
                end
            end
            SHFT: begin
                sr_d  = {sr_q[16:0], CmdIn};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd17) state_d = EVAL;
            end
            EVAL: begin
                state_d = IDLE;
                if (addr_hit && is_read && prty_ok) begin
                    read_strobe_d = 1'b1;
                    read_tag_d    = sr_q[1:0];
                end else if (addr_hit && is_read) begin
                    prty_err_d = 1'b1;
                end else if (addr_hit) begin
                    cmd_strobe_d = 1'b1;
                    cmd_word_d   = sr_q[13:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= 5'd0;
            sr_q          <= 18'd0;
            read_strobe_q <= 1'b0;
            cmd_strobe_q  <= 1'b0;
            prty_err_q    <= 1'b0;
            read_tag_q    <= 2'd0;
            cmd_word_q    <= 14'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            read_strobe_q <= read_strobe_d;
            cmd_strobe_q  <= cmd_strobe_d;
            prty_err_q    <= prty_err_d;
            read_tag_q    <= read_tag_d;
            cmd_word_q    <= cmd_word_d;
        end
    end
    assign RxBusy     = state_q != IDLE;
    assign ReadStrobe = read_strobe_q;
    assign CmdStrobe  = cmd_strobe_q;
    assign PrtyErr    = prty_err_q;
    assign ReadTag    = read_tag_q;
    assign CmdWord    = cmd_word_q;
`ifdef READ_CMD_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    always_comb begin
        err_cnt_d = (prty_err_d && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
    end
    always_ff @(posedge Clock) begin
        if (Reset) err_cnt_q <= 8'd0;
        else err_cnt_q <= err_cnt_d;
    end
    assign ErrCnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_read_cmd_decoder.sv
// tb_read_cmd_decoder: directed and randomized frames checked against a frame-level model.
module tb_read_cmd_decoder;
    localparam logic [10:0] RC = 11'b11111110010;
    logic        Clock, Reset, CmdIn;
    logic [3:0]  board_addr;
    logic        RxBusy, ReadStrobe, CmdStrobe, PrtyErr;
    logic [1:0]  ReadTag;
    logic [13:0] CmdWord;
`ifdef READ_CMD_ERRCNT_EN
    logic [7:0]  ErrCnt;
`endif
    int checks = 0;
    int errors = 0;
    logic [1:0]  exp_tag;
    logic [13:0] exp_word;
    int          exp_errcnt;

    read_cmd_decoder dut (
        .Clock(Clock), .Reset(Reset), .CmdIn(CmdIn), .BoardAddr(board_addr),
        .RxBusy(RxBusy), .ReadStrobe(ReadStrobe), .ReadTag(ReadTag),
        .CmdStrobe(CmdStrobe), .CmdWord(CmdWord), .PrtyErr(PrtyErr)
`ifdef READ_CMD_ERRCNT_EN
        , .ErrCnt(ErrCnt)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, " ReadTag"}, 32'(ReadTag), 32'(exp_tag));
        chk({tag, " CmdWord"}, 32'(CmdWord), 32'(exp_word));
`ifdef READ_CMD_ERRCNT_EN
        chk({tag, " ErrCnt"}, 32'(ErrCnt), 32'(exp_errcnt));
`endif
    endtask

    // Sends start + 18 bits; eval_in is driven during Eval, next_start right after it.
    task automatic frame(input string tag, input logic [17:0] d, input logic eval_in,
                         input logic next_start);
        logic       hit, rd, pok, rs, pe, cs;
        int         ones;
        if (!CmdIn) begin
            @(posedge Clock); #1 CmdIn = 1'b1;
        end
        for (int i = 17; i >= 0; i--) begin
            @(posedge Clock); #1 CmdIn = d[i];
            @(negedge Clock);
            chk({tag, " busy"}, 32'(RxBusy), 32'd1);
            chk({tag, " quiet"}, 32'({ReadStrobe, CmdStrobe, PrtyErr}), 32'd0);
        end
        @(posedge Clock); #1 CmdIn = eval_in;
        @(negedge Clock);
        chk({tag, " eval busy"}, 32'(RxBusy), 32'd1);
        chk({tag, " eval quiet"}, 32'({ReadStrobe, CmdStrobe, PrtyErr}), 32'd0);
        hit  = (d[17:14] == board_addr) || (d[17:14] == 4'hf);
        rd   = d[13:3] == RC;
        ones = int'(d[1]) + int'(d[0]);
        pok  = (ones % 2) == int'(d[2]);
        rs   = hit && rd && pok;
        pe   = hit && rd && !pok;
        cs   = hit && !rd;
        if (rs) exp_tag = d[1:0];
        if (cs) exp_word = d[13:0];
        if (pe && exp_errcnt < 255) exp_errcnt++;
        @(posedge Clock); #1 CmdIn = next_start;
        @(negedge Clock);
        chk({tag, " idle"}, 32'(RxBusy), 32'd0);
        chk({tag, " ReadStrobe"}, 32'(ReadStrobe), 32'(rs));
        chk({tag, " PrtyErr"}, 32'(PrtyErr), 32'(pe));
        chk({tag, " CmdStrobe"}, 32'(CmdStrobe), 32'(cs));
        chk_regs(tag);
    endtask

    initial begin
        logic [17:0] d;
        logic [3:0]  a;
        logic [10:0] w;
        Reset = 1'b1;
        CmdIn = 1'b0;
        board_addr = 4'b0011;
        exp_tag = 2'd0;
        exp_word = 14'd0;
        exp_errcnt = 0;
        repeat (3) @(posedge Clock);
        #1 CmdIn = 1'b1;
        @(negedge Clock);
        chk("reset busy", 32'(RxBusy), 32'd0);
        chk("reset strobes", 32'({ReadStrobe, CmdStrobe, PrtyErr}), 32'd0);
        chk_regs("reset");
        @(posedge Clock); #1 Reset = 1'b0; CmdIn = 1'b0;
        @(negedge Clock);
        chk("post reset busy", 32'(RxBusy), 32'd0);

        frame("read_wild", {4'b1111, RC, 1'b1, 2'b10}, 1'b0, 1'b0);
        frame("other_addr", {4'b0101, RC, 1'b1, 2'b01}, 1'b0, 1'b0);
        frame("prty_err", {4'b0011, RC, 1'b1, 2'b11}, 1'b1, 1'b0);
        frame("cmd_word", {4'b1111, 11'b11111100001, 3'b101}, 1'b0, 1'b0);
        chk("cmd_word value", 32'(CmdWord), 32'(14'b11111100001101));
        frame("b2b_1", {4'b0011, RC, 1'b1, 2'b01}, 1'b1, 1'b1);
        frame("b2b_2", {4'b0011, RC, 1'b1, 2'b10}, 1'b0, 1'b0);
        chk("b2b tag", 32'(ReadTag), 32'(2'b10));

        // Abort after 9 data bits; the remaining bits are low so no new start appears.
        d = {4'b0011, 11'b11111000000, 3'b000};
        @(posedge Clock); #1 CmdIn = 1'b1;
        for (int i = 17; i >= 9; i--) begin
            @(posedge Clock); #1 CmdIn = d[i];
        end
        @(posedge Clock); #1 Reset = 1'b1; CmdIn = d[8];
        @(posedge Clock); #1 Reset = 1'b0; CmdIn = d[7];
        exp_tag = 2'd0;
        exp_word = 14'd0;
        exp_errcnt = 0;
        @(negedge Clock);
        chk("abort busy", 32'(RxBusy), 32'd0);
        chk_regs("abort");
        for (int i = 6; i >= -4; i--) begin
            @(posedge Clock); #1 CmdIn = 1'b0;
            @(negedge Clock);
            chk("abort idle", 32'(RxBusy), 32'd0);
            chk("abort quiet", 32'({ReadStrobe, CmdStrobe, PrtyErr}), 32'd0);
        end
        frame("after_abort", {4'b0011, RC, 1'b0, 2'b11}, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: a = board_addr;
                1: a = 4'hf;
                default: a = 4'($urandom);
            endcase
            w = ($urandom_range(0, 1) == 1) ? RC : 11'($urandom);
            d = {a, w, 3'($urandom)};
            frame("random", d, 1'($urandom), 1'($urandom));
        end

        for (int n = 0; n < 300; n++) begin
            frame("sat", {4'b0011, RC, 1'b1, 2'b11}, 1'b0, 1'b0);
        end
`ifdef READ_CMD_ERRCNT_EN
        chk("errcnt saturated", 32'(ErrCnt), 32'd255);
`endif
        chk("final tag", 32'(ReadTag), 32'(exp_tag));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
